segasys1_sndcmd_rx: RTL and testbench
=====================================

// Module: segasys1_sndcmd_rx
// PURPOSE
//  Sound-side end of the main->sound command path. Captures each command byte the main CPU
//  posts on SNDNO/SNDRQ into a small FIFO and raises an edge-style NMI to the sound Z80.
//  The Z80 reads the byte back through its latch port. Sits inside the sound section,
//  between the main-CPU command outputs and the sound Z80 bus/NMI pin.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of two, 1..16 (DEPTH=1 = classic single latch)
//  NMI_LEN  4   NMI_N low time, counted in SCPU_CE ticks; 1..15
// PORTS
//  CLK48M    in   1  system clock; the only clock
//  RESET     in   1  synchronous, active-high reset
//  SNDRQ     in   1  main-CPU command strobe; a rising edge posts SNDNO
//  SNDNO     in   8  command byte; sampled in the same cycle the SNDRQ rise is detected
//  SCPU_CE   in   1  sound-CPU clock enable, 1-cycle pulse
//  SCPU_RD   in   1  sound-CPU latch read strobe, 1 cycle wide, CE-qualified by the caller
//  SCPU_DO   out  8  byte presented to the sound CPU
//  SCPU_NMI_N out 1  NMI to the sound Z80, active low
//  PEND      out  1  FIFO not empty
//  LEVEL     out  5  current FIFO occupancy, 0..DEPTH
//  OVF       out  1  sticky flag: a post arrived while the FIFO was full
// BEHAVIOUR
//  Reset: FIFO empty, LEVEL=0, PEND=0, OVF=0, SCPU_DO=8'h00, SCPU_NMI_N=1, FSM=IDLE,
//   SNDRQ edge register=1. A held-high SNDRQ coming out of reset therefore posts nothing.
//  Edge detect: rq_d <= SNDRQ. push = SNDRQ & ~rq_d. The byte is written at the end of that
//   cycle. PEND/LEVEL update 1 cycle after the edge-detect cycle.
//  Pop: pop = SCPU_RD & PEND. SCPU_DO is registered and tracks the FIFO head whenever PEND=1.
//   On pop the head pointer advances. When the FIFO is empty, SCPU_DO holds the last byte.
//   SCPU_RD while empty: no state change, the held byte is re-read.
//  Full + push, no pop: the newest entry (tail-1) is overwritten and OVF is set.
//   LEVEL is unchanged. With DEPTH=1, latest write wins.
//  Full + push + pop in the same cycle: a normal push and pop; LEVEL unchanged, OVF untouched.
//  Empty + push + SCPU_RD in the same cycle: the push proceeds and the read is ignored.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. LEVEL is kept separately; full is
//   LEVEL==DEPTH.
//  NMI FSM (states advance only on SCPU_CE, except where noted):
//   IDLE:   PEND=1 -> ASSERT. Load cnt=NMI_LEN and drive SCPU_NMI_N=0 on that CE.
//   ASSERT: cnt decrements per CE. At cnt==1 on a CE -> WAIT, SCPU_NMI_N=1.
//   WAIT:   SCPU_NMI_N=1. A pop (on any cycle, CE not required) -> REARM.
//   REARM:  one CE of guaranteed high time. Then PEND=1 -> ASSERT, else IDLE.
//   A pop during ASSERT is legal. It is recorded and WAIT is skipped: ASSERT -> REARM.
//   The NMI low pulse is always exactly NMI_LEN CE ticks, followed by at least 1 CE high.
//   One NMI is issued per popped byte (Z80 NMI is edge-triggered).
//  OVF clears only on RESET.
//  RESET mid-operation (any FSM state): everything returns to the reset values in the next
//   cycle. SCPU_NMI_N goes high immediately in that cycle.
// STRUCTURE
//  segasys1_pkg: localparams NMI_IDLE/NMI_ASSERT/NMI_WAIT/NMI_REARM (2-bit encoding),
//   CMD_W=8, LVL_W=5.
//  Sub-module segasys1_cmdfifo: synchronous FIFO with push/pop, overwrite-on-full, level
//   and overflow outputs. The top holds the edge detect, the SCPU_DO register and the NMI FSM.
// TESTING (CE every 4th clock, DEPTH=4, NMI_LEN=4)
//  1) Reset with SNDRQ held at 1, then release reset -> no push; LEVEL=0; SCPU_NMI_N stays 1.
//  2) SNDRQ 0->1 with SNDNO=8'h5A -> PEND=1 next cycle. NMI_N low for exactly 4 CE ticks.
//     SCPU_RD -> SCPU_DO=8'h5A, PEND=0, and no further NMI.
//  3) Post 8'h01..8'h04, then read 4 times -> reads in order 01,02,03,04.
//     4 separate NMI pulses, each followed by at least 1 CE of high time.
//  4) Post 01..04, then 8'hEE while full -> OVF=1, LEVEL=4, reads 01,02,03,EE.
//     A 5th read returns EE with no change of state.
//  5) FIFO full and a post of 8'h77 coincides with SCPU_RD -> LEVEL stays 4, OVF=0,
//     and 77 is the last byte out.
//  6) Assert RESET during ASSERT with LEVEL=2 -> the next cycle shows SCPU_NMI_N=1, LEVEL=0,
//     OVF=0, SCPU_DO=00.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared constants and types for the Sega System 1 sound-command receiver.
package segasys1_pkg;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned LVL_W = 5;

  // NMI sequencer state encoding
  localparam logic [1:0] NMI_IDLE   = 2'd0;
  localparam logic [1:0] NMI_ASSERT = 2'd1;
  localparam logic [1:0] NMI_WAIT   = 2'd2;
  localparam logic [1:0] NMI_REARM  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = NMI_IDLE,
    StAssert = NMI_ASSERT,
    StWait   = NMI_WAIT,
    StRearm  = NMI_REARM
  } nmi_state_e;

endpackage

// File: rtl/segasys1_cmdfifo.sv
// Small command FIFO: push/pop, overwrite-newest when full, occupancy and sticky overflow.
module segasys1_cmdfifo
  import segasys1_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [CMD_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] head_o,
  output logic [LVL_W-1:0] level_o,
  output logic             pend_o,
  output logic             ovf_o
);

  // DEPTH=1 still needs a 1-bit pointer; it simply never leaves zero.
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;

  logic full;
  logic pend;
  logic pop_ok;
  logic overwrite;
  logic push_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrMax : p - PtrW'(1);
  endfunction

  assign full      = (level_q == LVL_W'(DEPTH));
  assign pend      = (level_q != '0);
  assign pop_ok    = pop_i & pend;
  // A simultaneous pop frees a slot, so only an unaccompanied push into a full FIFO overwrites.
  assign overwrite = push_i & full & ~pop_ok;
  assign push_ok   = push_i & ~overwrite;

  // Next-state: memory write, pointer advance, occupancy and overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (overwrite) begin
      mem_d[ptr_dec(wr_ptr_q)] = wdata_i;
      ovf_d = 1'b1;
    end else if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign pend_o  = pend;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/segasys1_sndcmd_rx.sv
// Sound-side command receiver: SNDRQ edge capture into a FIFO, Z80 latch port and NMI sequencer.
module segasys1_sndcmd_rx
  import segasys1_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NMI_LEN = 4
) (
  input  logic             CLK48M,
  input  logic             RESET,
  input  logic             SNDRQ,
  input  logic [CMD_W-1:0] SNDNO,
  input  logic             SCPU_CE,
  input  logic             SCPU_RD,
  output logic [CMD_W-1:0] SCPU_DO,
  output logic             SCPU_NMI_N,
  output logic             PEND,
  output logic [LVL_W-1:0] LEVEL,
  output logic             OVF
);

  logic             rq_q;
  logic [CMD_W-1:0] do_q, do_d;
  nmi_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             popped_q, popped_d;
  logic             nmi_n_q, nmi_n_d;

  logic             push;
  logic             pop;
  logic             pend;
  logic [CMD_W-1:0] head;

  assign push = SNDRQ & ~rq_q;
  assign pop  = SCPU_RD & pend;

  segasys1_cmdfifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK48M),
    .rst_i   (RESET),
    .push_i  (push),
    .wdata_i (SNDNO),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (LEVEL),
    .pend_o  (pend),
    .ovf_o   (OVF)
  );

  // Latch port follows the FIFO head while anything is pending, otherwise holds the last byte.
  always_comb begin
    do_d = pend ? head : do_q;
  end

  // NMI sequencer next-state; one fixed-length low pulse per byte handed to the Z80.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    popped_d = popped_q;
    nmi_n_d  = nmi_n_q;

    case (state_q)
      StIdle: begin
        if (SCPU_CE && pend) begin
          state_d  = StAssert;
          cnt_d    = 4'(NMI_LEN);
          popped_d = 1'b0;
          nmi_n_d  = 1'b0;
        end
      end
      StAssert: begin
        // An early read is remembered so the WAIT handshake is skipped.
        if (pop) begin
          popped_d = 1'b1;
        end
        if (SCPU_CE) begin
          if (cnt_q == 4'd1) begin
            state_d = (popped_q || pop) ? StRearm : StWait;
            nmi_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StWait: begin
        if (pop) begin
          state_d = StRearm;
        end
      end
      StRearm: begin
        if (SCPU_CE) begin
          if (pend) begin
            state_d  = StAssert;
            cnt_d    = 4'(NMI_LEN);
            popped_d = 1'b0;
            nmi_n_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        nmi_n_d = 1'b1;
      end
    endcase
  end

  // Edge detector, latch register and NMI sequencer state.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      rq_q     <= 1'b1;
      do_q     <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      popped_q <= 1'b0;
      nmi_n_q  <= 1'b1;
    end else begin
      rq_q     <= SNDRQ;
      do_q     <= do_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      popped_q <= popped_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

  // Reset releases the NMI line in the same cycle rather than one clock later.
  assign SCPU_NMI_N = nmi_n_q | RESET;
  assign SCPU_DO    = do_q;
  assign PEND       = pend;

endmodule

// File: tb/tb_segasys1_sndcmd_rx.sv
// Bench for segasys1_sndcmd_rx: directed scenarios plus random rounds against a queue model.
module tb_segasys1_sndcmd_rx;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NMI_LEN = 4;

  logic       CLK48M  = 1'b0;
  logic       RESET   = 1'b1;
  logic       SNDRQ   = 1'b1;
  logic [7:0] SNDNO   = 8'h00;
  logic       SCPU_CE = 1'b0;
  logic       SCPU_RD = 1'b0;
  logic [7:0] SCPU_DO;
  logic       SCPU_NMI_N;
  logic       PEND;
  logic [4:0] LEVEL;
  logic       OVF;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: pending bytes, last byte handed out, sticky overflow.
  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00;
  logic       m_ovf  = 1'b0;

  // NMI pulse monitor state.
  int   falls   = 0;
  int   served  = 0;
  int   len_bad = 0;
  int   gap_bad = 0;
  int   low_ce  = 0;
  int   high_ce = 100;
  logic mon_prev = 1'b1;

  segasys1_sndcmd_rx #(
    .DEPTH   (DEPTH),
    .NMI_LEN (NMI_LEN)
  ) dut (
    .CLK48M     (CLK48M),
    .RESET      (RESET),
    .SNDRQ      (SNDRQ),
    .SNDNO      (SNDNO),
    .SCPU_CE    (SCPU_CE),
    .SCPU_RD    (SCPU_RD),
    .SCPU_DO    (SCPU_DO),
    .SCPU_NMI_N (SCPU_NMI_N),
    .PEND       (PEND),
    .LEVEL      (LEVEL),
    .OVF        (OVF)
  );

  always #5 CLK48M = ~CLK48M;

  // CE on every 4th clock, changed just after the rising edge.
  initial begin : ce_gen
    int div;
    div = 0;
    forever begin
      @(posedge CLK48M);
      #1;
      div = (div + 1) % 4;
      SCPU_CE = (div == 3);
    end
  end

  // Measures NMI low time and following high time in CE ticks.
  always @(posedge CLK48M) begin
    if (RESET) begin
      mon_prev <= 1'b1;
      low_ce   <= 0;
      high_ce  <= 100;
    end else begin
      mon_prev <= SCPU_NMI_N;
      if (!SCPU_NMI_N) begin
        if (mon_prev) begin
          falls <= falls + 1;
          if (high_ce < 1) gap_bad <= gap_bad + 1;
          low_ce <= int'(SCPU_CE);
        end else begin
          low_ce <= low_ce + int'(SCPU_CE);
        end
      end else begin
        if (!mon_prev) begin
          if (low_ce != NMI_LEN) len_bad <= len_bad + 1;
          high_ce <= int'(SCPU_CE);
        end else begin
          high_ce <= high_ce + int'(SCPU_CE);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK48M);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else begin
      mq[mq.size() - 1] = b;
      m_ovf = 1'b1;
    end
  endtask

  // Post one byte; optionally the Z80 reads in the very cycle the SNDRQ rise is seen.
  task automatic post(input logic [7:0] b, input bit rd);
    logic [7:0] exp;
    @(negedge CLK48M);
    SNDRQ   = 1'b0;
    SCPU_RD = 1'b0;
    @(negedge CLK48M);
    SNDRQ   = 1'b1;
    SNDNO   = b;
    SCPU_RD = rd;
    if (rd && mq.size() > 0) begin
      exp    = mq.pop_front();
      m_last = exp;
      check("post_rd_do", SCPU_DO, exp);
    end
    model_push(b);
    @(negedge CLK48M);
    SCPU_RD = 1'b0;
    SNDRQ   = 1'b0;
    check("post_level", LEVEL, mq.size());
    check("post_pend", PEND, mq.size() != 0);
    check("post_ovf", OVF, m_ovf);
  endtask

  task automatic read_byte(input string tag);
    logic [7:0] exp;
    SCPU_RD = 1'b1;
    exp = (mq.size() > 0) ? mq.pop_front() : m_last;
    m_last = exp;
    check(tag, SCPU_DO, exp);
    @(negedge CLK48M);
    SCPU_RD = 1'b0;
    check("read_level", LEVEL, mq.size());
    check("read_pend", PEND, mq.size() != 0);
  endtask

  task automatic wait_pulse(input string tag);
    int i;
    i = 0;
    while (falls <= served && i < 400) begin
      @(negedge CLK48M);
      i++;
    end
    check(tag, (falls > served) ? 1 : 0, 1);
    served++;
  endtask

  task automatic wait_high(input string tag);
    int i;
    i = 0;
    while (SCPU_NMI_N !== 1'b1 && i < 200) begin
      @(negedge CLK48M);
      i++;
    end
    check(tag, SCPU_NMI_N, 1'b1);
  endtask

  // One NMI handshake: wait for the pulse, read during it or after it.
  task automatic serve_read(input string tag);
    wait_pulse("nmi_pulse_seen");
    if ($urandom_range(0, 1) == 1) wait_high("nmi_release");
    read_byte(tag);
  endtask

  task automatic quiet_check(input string tag);
    tick(40);
    check(tag, falls, served);
  endtask

  task automatic do_reset();
    @(negedge CLK48M);
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    mq.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    served = falls;
  endtask

  initial begin
    // 1) reset with SNDRQ high: nothing posted on release
    tick(3);
    RESET = 1'b0;
    tick(10);
    check("rst_level", LEVEL, 0);
    check("rst_pend", PEND, 0);
    check("rst_nmi", SCPU_NMI_N, 1);
    check("rst_do", SCPU_DO, 8'h00);
    check("rst_ovf", OVF, 0);
    check("rst_no_pulse", falls, 0);

    // 2) single byte, one pulse, read, no further NMI
    post(8'h5A, 1'b0);
    serve_read("t2_do");
    check("t2_do_held", SCPU_DO, 8'h5A);
    quiet_check("t2_no_extra_nmi");

    // 3) four bytes read in order, one pulse each
    for (int i = 1; i <= 4; i++) post(8'(i), 1'b0);
    for (int i = 0; i < 4; i++) serve_read("t3_do");
    quiet_check("t3_pulse_count");

    // 4) overflow overwrites the newest entry; empty read repeats the last byte
    for (int i = 1; i <= 4; i++) post(8'(i), 1'b0);
    post(8'hEE, 1'b0);
    check("t4_ovf", OVF, 1);
    check("t4_level", LEVEL, 4);
    for (int i = 0; i < 4; i++) serve_read("t4_do");
    tick(2);
    read_byte("t4_empty_do");
    check("t4_empty_val", SCPU_DO, 8'hEE);
    quiet_check("t4_no_extra_nmi");

    // 5) full FIFO, post coinciding with read: plain push+pop
    do_reset();
    for (int i = 1; i <= 4; i++) post(8'(i), 1'b0);
    wait_pulse("t5_first_pulse");
    post(8'h77, 1'b1);
    check("t5_level", LEVEL, 4);
    check("t5_ovf", OVF, 0);
    for (int i = 0; i < 4; i++) serve_read("t5_do");
    check("t5_last", SCPU_DO, 8'h77);
    quiet_check("t5_no_extra_nmi");

    // 6) reset in the middle of an NMI pulse
    do_reset();
    for (int i = 1; i <= 4; i++) post(8'(i), 1'b0);
    post(8'hEE, 1'b0);
    serve_read("t6_do");
    serve_read("t6_do");
    wait_pulse("t6_third_pulse");
    check("t6_pre_nmi_low", SCPU_NMI_N, 0);
    check("t6_pre_level", LEVEL, 2);
    check("t6_pre_ovf", OVF, 1);
    RESET = 1'b1;
    #1;
    check("t6_nmi_immediate", SCPU_NMI_N, 1);
    @(negedge CLK48M);
    check("t6_nmi", SCPU_NMI_N, 1);
    check("t6_level", LEVEL, 0);
    check("t6_ovf", OVF, 0);
    check("t6_do", SCPU_DO, 8'h00);
    check("t6_pend", PEND, 0);
    RESET = 1'b0;
    mq.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    served = falls;
    tick(4);

    // random rounds against the model
    for (int r = 0; r < 8; r++) begin
      int k;
      k = $urandom_range(1, DEPTH + 2);
      for (int j = 0; j < k; j++) post(8'($urandom_range(0, 255)), 1'b0);
      while (mq.size() > 0) serve_read("rnd_do");
      if ($urandom_range(0, 1) == 1) begin
        tick(2);
        read_byte("rnd_empty_do");
      end
      quiet_check("rnd_pulse_count");
    end

    check("nmi_low_len", len_bad, 0);
    check("nmi_high_gap", gap_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
